// File: rtl/aw_write_responder.sv
// ---------------------------------------------------------------------------
// aw_write_responder
//
// Consumer end of the write-address FIFO in a crossbar slave port. Pops one
// queued AW entry, accepts the matching W beats while generating a per-beat
// address (FIXED / INCR / WRAP), drives a simple memory write port, checks
// WLAST framing and returns one B response per burst. One burst in flight.
//
// Ports
//   ACLK, ARESETn        clock, synchronous active-low reset
//   fifo_empty/fifo_pop  AW FIFO handshake (pop is combinational in IDLE)
//   front_AW*            AW FIFO front entry (ID, ADDR, LEN, SIZE, BURST)
//   W*                   AXI write data channel (slave side)
//   mem_*                memory write port, one mem_we pulse per good beat
//   B*                   AXI write response channel (slave side)
// ---------------------------------------------------------------------------
module aw_write_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic [ID_WIDTH-1:0]     front_AWID,
    input  logic [ADDR_WIDTH-1:0]   front_AWADDR,
    input  logic [LEN_WIDTH-1:0]    front_AWLEN,
    input  logic [SIZE_WIDTH-1:0]   front_AWSIZE,
    input  logic [1:0]              front_AWBURST,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // Address sequencing decided once at pop; reserved bursts and WRAP with
    // an illegal length both walk as INCR.
    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_WRAP  = 2'd2
    } addr_mode_t;

    state_t                  state_q, state_d;
    addr_mode_t              mode_q, front_mode;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [ADDR_WIDTH-1:0]   nbytes;
    logic [ADDR_WIDTH-1:0]   total;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_cnt_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic                    cfg_err_q;
    logic                    err_q;
    logic                    front_wrap_len_ok;
    logic                    front_cfg_err;
    logic                    beat_fire;
    logic                    last_beat;

    // ---------------- front entry decode ----------------
    assign front_wrap_len_ok = (front_AWLEN == LEN_WIDTH'(1))  ||
                               (front_AWLEN == LEN_WIDTH'(3))  ||
                               (front_AWLEN == LEN_WIDTH'(7))  ||
                               (front_AWLEN == LEN_WIDTH'(15));

    assign front_cfg_err = (int'(front_AWSIZE) > MAX_SIZE) ||
                           (front_AWBURST == 2'b11) ||
                           ((front_AWBURST == 2'b10) && !front_wrap_len_ok);

    always_comb begin
        front_mode = MODE_INCR;
        if (front_AWBURST == 2'b00)
            front_mode = MODE_FIXED;
        else if ((front_AWBURST == 2'b10) && front_wrap_len_ok)
            front_mode = MODE_WRAP;
    end

    // ---------------- handshakes and outputs ----------------
    // Gating with ARESETn keeps the FIFO from losing an entry on a reset edge.
    assign fifo_pop  = ARESETn && (state_q == IDLE) && !fifo_empty;
    assign WREADY    = (state_q == DATA);
    assign beat_fire = WVALID && WREADY;
    assign last_beat = (beat_cnt_q == len_q);

    assign mem_we    = beat_fire && !cfg_err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = WDATA;
    assign mem_wstrb = mem_we ? WSTRB : '0;

    assign BVALID    = (state_q == RESP);
    assign BID       = id_q;
    assign BRESP     = BVALID ? {err_q, 1'b0} : 2'b00;

    // ---------------- address generation ----------------
    assign nbytes = ADDR_WIDTH'(1) << size_q;
    assign total  = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_addr = addr_q;
        case (mode_q)
            MODE_FIXED: next_addr = addr_q;
            // Stays inside the total-sized window; low bits of an unaligned
            // start are carried along by the window offset.
            MODE_WRAP:  next_addr = (addr_q & ~(total - ADDR_WIDTH'(1))) |
                                    ((addr_q + nbytes) & (total - ADDR_WIDTH'(1)));
            // Align first so an unaligned beat 0 snaps onto the size grid.
            default:    next_addr = (addr_q & ~(nbytes - ADDR_WIDTH'(1))) + nbytes;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge ACLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge
        // values regardless of process ordering.
        if (!ARESETn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_pop)               state_d = DATA;
            DATA:    if (beat_fire && last_beat) state_d = RESP;
            RESP:    if (BREADY)                 state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // ---------------- burst context ----------------
    always_ff @(posedge ACLK) begin
        // NOTE: the latched burst fields are reset too, even though they are
        // don't-care in IDLE, because mem_addr and BID are read straight from
        // them and must come out of reset as 0.
        if (!ARESETn) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            mode_q     <= MODE_FIXED;
            beat_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            err_q      <= 1'b0;
        end else if (fifo_pop) begin
            id_q       <= front_AWID;
            addr_q     <= front_AWADDR;
            len_q      <= front_AWLEN;
            size_q     <= front_AWSIZE;
            mode_q     <= front_mode;
            beat_cnt_q <= '0;
            cfg_err_q  <= front_cfg_err;
            err_q      <= front_cfg_err;
        end else if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
            addr_q     <= next_addr;
            if (WLAST != last_beat)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aw_write_responder.sv
module tb_aw_write_responder;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int LW  = 4;
    localparam int SW  = 3;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;

    logic           ACLK = 1'b0;
    logic           ARESETn;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [IDW-1:0] front_AWID;
    logic [AW-1:0]  front_AWADDR;
    logic [LW-1:0]  front_AWLEN;
    logic [SW-1:0]  front_AWSIZE;
    logic [1:0]     front_AWBURST;
    logic [DW-1:0]  WDATA;
    logic [BW-1:0]  WSTRB;
    logic           WLAST;
    logic           WVALID;
    logic           WREADY;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [BW-1:0]  mem_wstrb;
    logic [IDW-1:0] BID;
    logic [1:0]     BRESP;
    logic           BVALID;
    logic           BREADY;

    aw_write_responder #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .SIZE_WIDTH(SW), .DATA_WIDTH(DW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .front_AWID(front_AWID), .front_AWADDR(front_AWADDR),
        .front_AWLEN(front_AWLEN), .front_AWSIZE(front_AWSIZE),
        .front_AWBURST(front_AWBURST),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        logic [SW-1:0]  size;
        logic [1:0]     burst;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] strb;
        logic          last;
    } w_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] strb;
    } beat_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    aw_t   aw_q[$];
    w_t    w_q[$];
    beat_t exp_beat_q[$];
    b_t    exp_b_q[$];

    int tests = 0;
    int fails = 0;
    int pop_count = 0;
    int issued = 0;
    int we_count = 0;
    int b_count = 0;
    int bready_mode = 0;   // 0 random, 1 held low, 2 held high
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic wrap_ok(input logic [LW-1:0] len);
        int beats;
        beats = int'(len) + 1;
        return (beats == 2) || (beats == 4) || (beats == 8) || (beats == 16);
    endfunction

    function automatic logic cfg_err(input aw_t a);
        return (int'(a.size) > $clog2(BW)) || (a.burst == 2'b11) ||
               ((a.burst == 2'b10) && !wrap_ok(a.len));
    endfunction

    function automatic logic [AW-1:0] beat_addr(input aw_t a, input int k);
        logic [AW-1:0] n, step, total, lo;
        n    = 32'd1 << a.size;
        step = n * 32'(k);
        if (a.burst == 2'b00) return a.addr;
        if (a.burst == 2'b10 && wrap_ok(a.len)) begin
            total = (32'(a.len) + 32'd1) * n;
            lo    = a.addr - (a.addr % total);
            return lo + ((a.addr - lo + step) % total);
        end
        if (k == 0) return a.addr;
        return a.addr - (a.addr % n) + step;
    endfunction

    // last_sel: -1 correct WLAST, -2 randomly corrupted, >=0 WLAST only on that beat
    task automatic queue_burst(input aw_t a, input int last_sel, input int nbeats);
        logic  ce, bad;
        w_t    w;
        beat_t e;
        b_t    b;
        ce  = cfg_err(a);
        bad = 1'b0;
        aw_q.push_back(a);
        issued++;
        for (int k = 0; k < nbeats; k++) begin
            w.data = $urandom();
            w.strb = BW'($urandom_range(15));
            if (last_sel == -1)
                w.last = (k == int'(a.len));
            else if (last_sel == -2)
                w.last = ($urandom_range(3) == 0) ? (k != int'(a.len)) : (k == int'(a.len));
            else
                w.last = (k == last_sel);
            if (w.last != (k == int'(a.len))) bad = 1'b1;
            w_q.push_back(w);
            e.we   = !ce;
            e.addr = beat_addr(a, k);
            e.data = w.data;
            e.strb = w.strb;
            exp_beat_q.push_back(e);
        end
        b.id   = a.id;
        b.resp = (ce || bad) ? 2'b10 : 2'b00;
        exp_b_q.push_back(b);
    endtask

    function automatic aw_t rand_aw();
        aw_t a;
        a.id    = IDW'($urandom_range(15));
        a.addr  = ($urandom_range(1) == 0) ? $urandom() : 32'($urandom_range(255));
        a.len   = LW'($urandom_range(15));
        a.size  = ($urandom_range(4) == 0) ? SW'($urandom_range(7)) : SW'($urandom_range(2));
        a.burst = 2'($urandom_range(3));
        return a;
    endfunction

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((exp_b_q.size() != 0 || exp_beat_q.size() != 0 || aw_q.size() != 0) && c < budget) begin
            @(negedge ACLK);
            c++;
        end
        check("drain_done", 64'(exp_b_q.size() + exp_beat_q.size() + aw_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_pop"}, 64'(fifo_pop), 64'd0);
        check({tag, "_wready"},   64'(WREADY),   64'd0);
        check({tag, "_mem_we"},   64'(mem_we),   64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wstrb"},64'(mem_wstrb),64'd0);
        check({tag, "_bid"},      64'(BID),      64'd0);
        check({tag, "_bresp"},    64'(BRESP),    64'd0);
        check({tag, "_bvalid"},   64'(BVALID),   64'd0);
    endtask

    // ---------------- stimulus driver (AW FIFO model, W, BREADY) ----------------
    always begin : driver
        logic s_rst, s_pop, s_wfire;
        @(negedge ACLK);
        s_rst   = ARESETn;
        s_pop   = fifo_pop;
        s_wfire = WVALID && WREADY;
        @(posedge ACLK);
        #1;
        if (s_rst) begin
            if (s_pop && aw_q.size() > 0) begin
                void'(aw_q.pop_front());
                pop_count++;
            end
            if (s_wfire && w_q.size() > 0) void'(w_q.pop_front());
        end
        fifo_empty = (aw_q.size() == 0);
        if (aw_q.size() > 0) begin
            front_AWID    = aw_q[0].id;
            front_AWADDR  = aw_q[0].addr;
            front_AWLEN   = aw_q[0].len;
            front_AWSIZE  = aw_q[0].size;
            front_AWBURST = aw_q[0].burst;
        end
        if (w_q.size() > 0 && $urandom_range(3) != 0) begin
            WVALID = 1'b1;
            WDATA  = w_q[0].data;
            WSTRB  = w_q[0].strb;
            WLAST  = w_q[0].last;
        end else begin
            WVALID = 1'b0;
            WDATA  = $urandom();
            WSTRB  = '0;
            WLAST  = 1'b0;
        end
        case (bready_mode)
            0:       BREADY = 1'($urandom_range(1));
            1:       BREADY = 1'b0;
            default: BREADY = 1'b1;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge ACLK) begin
        beat_t e;
        b_t    b;
        if (ARESETn && mon_en) begin
            if (fifo_empty) check("pop_when_empty", 64'(fifo_pop), 64'd0);
            if (WVALID && WREADY) begin
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_beat_q.pop_front();
                    check("mem_we", 64'(mem_we), 64'(e.we));
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) begin
                        check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                        check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
                    end else begin
                        check("mem_wstrb_off", 64'(mem_wstrb), 64'd0);
                    end
                end
            end else begin
                check("mem_we_idle", 64'(mem_we), 64'd0);
            end
            if (mem_we) we_count++;
            if (BVALID) begin
                check("wready_in_resp", 64'(WREADY), 64'd0);
                if (exp_b_q.size() == 0) begin
                    check("unexpected_b", 64'd1, 64'd0);
                end else begin
                    b = exp_b_q[0];
                    check("bid", 64'(BID), 64'(b.id));
                    check("bresp", 64'(BRESP), 64'(b.resp));
                    if (BREADY) begin
                        void'(exp_b_q.pop_front());
                        b_count++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        aw_t a;
        int  we0, b0, c;

        ARESETn = 1'b0; fifo_empty = 1'b1; WVALID = 1'b0; WLAST = 1'b0;
        WDATA = '0; WSTRB = '0; BREADY = 1'b0;
        front_AWID = '0; front_AWADDR = '0; front_AWLEN = '0;
        front_AWSIZE = '0; front_AWBURST = '0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("reset");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        mon_en  = 1'b1;

        // INCR 0x1000, four beats, ID 5
        we0 = we_count;
        a = '{id: 4'd5, addr: 32'h1000, len: 4'd3, size: 3'd2, burst: 2'b01};
        queue_burst(a, -1, 4);
        wait_drain(300);
        check("incr_we_pulses", 64'(we_count - we0), 64'd4);
        check("incr_pops", 64'(pop_count), 64'd1);

        // WRAP 0x2008 -> 2008, 200C, 2000, 2004
        a = '{id: 4'd3, addr: 32'h2008, len: 4'd3, size: 3'd2, burst: 2'b10};
        queue_burst(a, -1, 4);
        wait_drain(300);

        // FIXED with early WLAST on beat 1 -> SLVERR, still three beats
        a = '{id: 4'd7, addr: 32'h30, len: 4'd2, size: 3'd2, burst: 2'b00};
        queue_burst(a, 1, 3);
        wait_drain(300);

        // oversized beat: beats accepted, no memory writes
        we0 = we_count;
        a = '{id: 4'd9, addr: 32'h40, len: 4'd1, size: 3'd3, burst: 2'b01};
        queue_burst(a, -1, 2);
        wait_drain(300);
        check("size_err_we_pulses", 64'(we_count - we0), 64'd0);

        // back-pressured response with a second entry queued behind it
        bready_mode = 1;
        b0 = b_count;
        a = '{id: 4'd1, addr: 32'h100, len: 4'd1, size: 3'd2, burst: 2'b01};
        queue_burst(a, -1, 2);
        a = '{id: 4'd2, addr: 32'h200, len: 4'd0, size: 3'd1, burst: 2'b01};
        queue_burst(a, -1, 1);
        c = 0;
        while (!BVALID && c < 300) begin
            @(negedge ACLK);
            c++;
        end
        check("stall_bvalid_seen", 64'(BVALID), 64'd1);
        repeat (5) begin
            @(negedge ACLK);
            check("stall_bvalid", 64'(BVALID), 64'd1);
            check("stall_bid", 64'(BID), 64'd1);
            check("stall_wready", 64'(WREADY), 64'd0);
            check("stall_pop", 64'(fifo_pop), 64'd0);
        end
        bready_mode = 2;
        wait_drain(300);
        check("stall_b_count", 64'(b_count - b0), 64'd2);
        bready_mode = 0;

        // randomized bursts
        for (int i = 0; i < 40; i++) begin
            a = rand_aw();
            queue_burst(a, ($urandom_range(3) == 0) ? -2 : -1, int'(a.len) + 1);
        end
        wait_drain(20000);

        // reset in the middle of a burst: only two of four beats are offered
        bready_mode = 2;
        a = '{id: 4'd6, addr: 32'h500, len: 4'd3, size: 3'd2, burst: 2'b01};
        queue_burst(a, -1, 2);
        c = 0;
        while (exp_beat_q.size() != 0 && c < 300) begin
            @(negedge ACLK);
            c++;
        end
        check("mid_burst_beats", 64'(exp_beat_q.size()), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        mon_en  = 1'b0;
        exp_b_q.delete();
        exp_beat_q.delete();
        w_q.delete();
        @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("mid_reset");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (4) begin
            @(negedge ACLK);
            check("post_reset_pop", 64'(fifo_pop), 64'd0);
            check("post_reset_bvalid", 64'(BVALID), 64'd0);
        end
        mon_en = 1'b1;

        // recovery after reset
        bready_mode = 0;
        a = '{id: 4'd12, addr: 32'h7FC, len: 4'd7, size: 3'd2, burst: 2'b10};
        queue_burst(a, -1, 8);
        wait_drain(500);

        check("total_pops", 64'(pop_count), 64'(issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aw_write_responder.md
Name: aw_write_responder

Overview:
- Consumer end of the write-address FIFO in the crossbar slave port.
- Pops one queued AW entry, then accepts the matching W-channel beats and generates a per-beat write address (FIXED/INCR/WRAP).
- Drives a simple memory-side write port, checks WLAST framing, and returns one B response per burst with the latched ID.
- One burst in flight at a time; bursts are served in FIFO order.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, address width
LEN_WIDTH, 4, AWLEN width (max burst length 2^LEN_WIDTH beats)
SIZE_WIDTH, 3, AWSIZE width
DATA_WIDTH, 32, W data width in bits; must be a power of 2, at least 8

Ports:
ACLK  input  1  clock
ARESETn  input  1  synchronous active-low reset
fifo_empty  input  1  AW FIFO empty flag
fifo_pop  output  1  pops the AW FIFO front entry
front_AWID  input  ID_WIDTH  FIFO front ID
front_AWADDR  input  ADDR_WIDTH  FIFO front start address
front_AWLEN  input  LEN_WIDTH  FIFO front beats minus 1
front_AWSIZE  input  SIZE_WIDTH  FIFO front log2 bytes per beat
front_AWBURST  input  2  FIFO front burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
WDATA  input  DATA_WIDTH  write data
WSTRB  input  DATA_WIDTH/8  byte strobes
WLAST  input  1  last beat marker
WVALID  input  1  W valid
WREADY  output  1  W ready
mem_we  output  1  memory write enable, one cycle per accepted beat
mem_addr  output  ADDR_WIDTH  beat address
mem_wdata  output  DATA_WIDTH  equals WDATA
mem_wstrb  output  DATA_WIDTH/8  equals WSTRB while mem_we=1, else 0
BID  output  ID_WIDTH  response ID
BRESP  output  2  00 OKAY, 10 SLVERR
BVALID  output  1  B valid
BREADY  input  1  B ready

Behaviour:
- Reset: ACLK is the clock; ARESETn is a synchronous active-low reset. When ARESETn=0 at a rising edge, the block enters IDLE.
  - All outputs reset to 0: fifo_pop, WREADY, mem_we, mem_addr, mem_wstrb, BID, BRESP, BVALID.
  - Beat counter and error flag are cleared.
  - Reset mid-burst or mid-response abandons the burst; no B response is issued.
- State machine: IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - fifo_pop = ~fifo_empty (combinational); fifo_pop is never asserted while fifo_empty=1.
  - On the edge where fifo_pop=1, latch ID, ADDR, LEN, SIZE and BURST; clear beat_cnt; go to DATA.
- Configuration error (sets sticky err, latched at pop):
  - AWSIZE > log2(DATA_WIDTH/8).
  - AWBURST = 11.
  - WRAP with LEN not in {1, 3, 7, 15}.
- DATA:
  - WREADY=1.
  - On WVALID&WREADY: mem_we = ~cfg_err (combinational, same cycle). mem_addr = current beat address. Increment beat_cnt.
  - WLAST mismatch sets err: WLAST=1 with beat_cnt≠LEN, or WLAST=0 with beat_cnt=LEN.
  - The beat with beat_cnt=LEN ends the burst and moves to RESP, regardless of WLAST.
  - WVALID=0 stalls with no state change.
- Address generation (all arithmetic modulo 2^ADDR_WIDTH; 4KB crossing is not checked):
  - nbytes = 1<<SIZE; aligned = ADDR & ~(nbytes-1).
  - FIXED: every beat uses ADDR.
  - INCR (and reserved 11): beat 0 uses ADDR; beat k uses aligned + k*nbytes.
  - WRAP: total = (LEN+1)*nbytes; lo = ADDR & ~(total-1); next = lo | ((cur + nbytes) & (total-1)).
  - WRAP with an illegal LEN is computed as INCR.
- RESP:
  - BVALID=1, BID = latched ID, BRESP = err ? 10 : 00.
  - BID and BRESP are held stable until BREADY.
  - On BVALID&BREADY go to IDLE. The next pop may occur no earlier than the following cycle.
- Throughput: a burst occupies at least LEN+3 cycles (pop, LEN+1 beats, response). WREADY=0 outside DATA.

Test Plan:
- INCR, ADDR=0x1000, LEN=3, SIZE=2, ID=5, WLAST on beat 3 -> mem_addr 0x1000/0x1004/0x1008/0x100C, four mem_we pulses, BID=5, BRESP=00, one fifo_pop.
- WRAP, ADDR=0x2008, LEN=3, SIZE=2 -> addresses 0x2008, 0x200C, 0x2000, 0x2004; BRESP=00.
- FIXED, ADDR=0x30, LEN=2, with WLAST asserted on beat 1 -> all beats to 0x30, burst still ends after beat 2, BRESP=10.
- SIZE=3 with DATA_WIDTH=32, LEN=1 -> two beats accepted, mem_we stays 0, BRESP=10.
- Two entries queued (IDs 1 then 2), BREADY held 0 for 5 cycles -> BVALID=1 with BID=1 stable for 5 cycles, WREADY=0 and no pop until handshake; then ID 2 is served.
- ARESETn=0 after beat 1 of a LEN=3 INCR burst -> all outputs 0 the next cycle, no BVALID; after release with fifo_empty=1, fifo_pop stays 0.
